// File: rtl/br_mulfeed_pkg.sv
// Shared constants for the BR Barrett reduction path. The BR core and the
// br_mulfeed front end both import this, so widths and modulus stay in step.
package br_mulfeed_pkg;

   localparam int DATA_WIDTH        = 22;
   localparam int DOUBLE_DATA_WIDTH = 44;

   // Modulus; 2146043 < 2^22 so it fits the operand width.
   localparam logic [DATA_WIDTH-1:0] Prime = 22'd2146043;

   // Barrett constants used by BR: q = ((x >> rf_FRI) * pre_computing) >> rf_SEC,
   // with pre_computing = floor(2^44 / Prime).
   localparam int                    rf_FRI        = DATA_WIDTH - 1;
   localparam int                    rf_SEC        = DATA_WIDTH + 1;
   localparam logic [DATA_WIDTH+1:0] pre_computing = 24'd8197499;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
   } operand_t;

   // True when an operand is a proper residue.
   function automatic logic in_range(input logic [DATA_WIDTH-1:0] x);
      return x < Prime;
   endfunction

endpackage

// File: rtl/br_mulfeed_if.sv
// Operand-in / result-out valid-ready bus for br_mulfeed.
// master = upstream/downstream environment, slave = br_mulfeed.
interface br_mulfeed_if;
   import br_mulfeed_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_a;
   logic [DATA_WIDTH-1:0] in_b;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/br_result_fifo.sv
// Small register-based result FIFO. Head is a mux on rd_ptr over registered
// storage, so it is stable while nothing pops. Reusable for other reduction units.
module br_result_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 22,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pop on empty is ignored; push on full only lands if a pop frees the slot.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign head  = mem[rd_ptr];

   // Storage, pointers (wrap naturally at power-of-2 depth) and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/br_mulfeed.sv
// Issue/collect front end for BR: registers operand pairs, forms the 44-bit
// product for BR's S_in, and queues BR's result for the downstream consumer.
// BR cannot stall, so accepts are gated by credits covering every op that is
// in the pipe or sitting in the result FIFO.
module br_mulfeed
   import br_mulfeed_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   br_mulfeed_if.slave                  bus,
   output logic [DOUBLE_DATA_WIDTH-1:0] s_out,
   input  logic [DATA_WIDTH-1:0]        br_result,
   output logic                         range_err
);

   localparam int UW = CNT_WIDTH + 1;

   // vld_pipe[0]: operands registered, [1]: s_out valid, [2]: BR result valid.
   logic [2:0]           vld_pipe;
   operand_t             op_r;
   logic                 accept;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CNT_WIDTH-1:0] fifo_count;
   logic [UW-1:0]        credits_used;

   // Every op accepted and not yet popped holds one credit.
   assign credits_used = UW'(fifo_count) + UW'(vld_pipe[0]) + UW'(vld_pipe[1])
                       + UW'(vld_pipe[2]);

   // Registers only; no same-cycle path from in_valid or out_ready.
   assign bus.in_ready = ~rst & ~fifo_full & (credits_used < UW'(FIFO_DEPTH));
   assign accept       = bus.in_valid & bus.in_ready;
   assign pop          = bus.out_valid & bus.out_ready;

   // Operand capture, valid shift, product stage and sticky range flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r      <= '0;
         vld_pipe  <= '0;
         s_out     <= '0;
         range_err <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[1:0], accept};
         if (accept) begin
            op_r.a <= bus.in_a;
            op_r.b <= bus.in_b;
            if (!in_range(bus.in_a) || !in_range(bus.in_b)) range_err <= 1'b1;
         end
         if (vld_pipe[0])
            s_out <= DOUBLE_DATA_WIDTH'(op_r.a) * DOUBLE_DATA_WIDTH'(op_r.b);
      end
   end

   br_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH),
      .CW    (CNT_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (vld_pipe[2]),
      .push_data (br_result),
      .pop       (pop),
      .head      (bus.out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign bus.out_valid = ~fifo_empty;

endmodule

// File: tb/tb_br_mulfeed.sv
// Bench for br_mulfeed with a behavioural BR stand-in (registered s_out mod Prime).
module tb_br_mulfeed;
   import br_mulfeed_pkg::*;

   typedef struct {
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
      logic [DATA_WIDTH-1:0] exp;
      bit                    chk;
   } vec_t;

   logic                         clk = 1'b0;
   logic                         rst;
   logic [DOUBLE_DATA_WIDTH-1:0] s_out;
   logic [DATA_WIDTH-1:0]        br_result;
   logic                         range_err;

   br_mulfeed_if bif();

   br_mulfeed #(.FIFO_DEPTH(4), .CNT_WIDTH(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bif),
      .s_out     (s_out),
      .br_result (br_result),
      .range_err (range_err)
   );

   always #5 clk = ~clk;

   // BR stand-in: registers s_out mod Prime one edge after s_out updates.
   always @(posedge clk or posedge rst) begin
      if (rst) br_result <= '0;
      else     br_result <= DATA_WIDTH'(s_out % DOUBLE_DATA_WIDTH'(Prime));
   end

   vec_t stim[$];
   vec_t exp_q[$];
   int   tests = 0, fails = 0;
   int   cyc = 0, acc_cnt = 0, rcv_cnt = 0, last_acc = 0, ovf_cnt = 0;
   bit   rand_rdy = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   // Driver: present the head of the stimulus queue just after each edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst || stim.size() == 0) bif.in_valid = 1'b0;
         else begin
            bif.in_valid = 1'b1;
            bif.in_a     = stim[0].a;
            bif.in_b     = stim[0].b;
         end
         if (rand_rdy) bif.out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Issue side: on handshake push the expected response into the scoreboard.
   always @(negedge clk) begin
      if (!rst && bif.in_valid && bif.in_ready && stim.size() != 0) begin
         exp_q.push_back(stim[0]);
         void'(stim.pop_front());
         acc_cnt++;
         last_acc = cyc + 1;
      end
   end

   // Monitor: compare every result the DUT hands downstream.
   always @(negedge clk) begin
      vec_t e;
      if (!rst && bif.out_valid && bif.out_ready) begin
         rcv_cnt++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL out_unexpected: got %0d expected no result", bif.out_data);
         end else begin
            e = exp_q.pop_front();
            if (e.chk) check("out_data", 64'(bif.out_data), 64'(e.exp));
         end
      end
      if (!rst && dut.fifo_full && dut.vld_pipe[2] && !(bif.out_valid && bif.out_ready))
         ovf_cnt++;
   end

   task automatic put(input int a, input int b, input int e, input bit chk);
      vec_t v;
      v.a = DATA_WIDTH'(a); v.b = DATA_WIDTH'(b); v.exp = DATA_WIDTH'(e); v.chk = chk;
      stim.push_back(v);
   endtask

   task automatic wait_to(input int n);
      while (cyc < n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_acc(input int n);
      for (int i = 0; i < 60 && acc_cnt < n; i++) @(negedge clk);
      check("accept_count", 64'(acc_cnt), 64'(n));
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && (stim.size() != 0 || exp_q.size() != 0); i++) begin
         @(posedge clk); #1;
      end
      check("drain_left", 64'(stim.size() + exp_q.size()), 64'd0);
   endtask

   initial begin
      int t, base, rbase;
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, base, rbase, a, b;
      rst = 1'b1;
      bif.in_valid = 1'b0; bif.in_a = '0; bif.in_b = '0; bif.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  64'(bif.in_ready),  64'd0);
      check("rst_out_valid", 64'(bif.out_valid), 64'd0);
      check("rst_out_data",  64'(bif.out_data),  64'd0);
      check("rst_s_out",     64'(s_out),         64'd0);
      check("rst_range_err", 64'(range_err),     64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_in_ready", 64'(bif.in_ready), 64'd1);

      // 1: single op latency
      bif.out_ready = 1'b1;
      put(3, 5, 15, 1);
      wait_acc(1);
      t = last_acc;
      wait_to(t + 1);
      check("t1_s_out", 64'(s_out), 64'd15);
      check("t1_ov_T1", 64'(bif.out_valid), 64'd0);
      wait_to(t + 2);
      check("t1_ov_T2", 64'(bif.out_valid), 64'd0);
      wait_to(t + 3);
      check("t1_ov_T3", 64'(bif.out_valid), 64'd1);
      wait_drain(20);

      // 2: max operands
      put(2146042, 2146042, 1, 1);
      wait_acc(2);
      t = last_acc;
      wait_to(t + 1);
      check("t2_s_out", 64'(s_out), 64'd4605496265764);
      wait_drain(20);

      // 3: backpressure, 6 pairs against 4 credits
      bif.out_ready = 1'b0;
      base = acc_cnt; rbase = rcv_cnt;
      put(2, 3, 6, 1);       put(4, 5, 20, 1);    put(1000, 1000, 1000000, 1);
      put(2000, 3000, 1707914, 1); put(10, 11, 110, 1); put(1, 1, 1, 1);
      repeat (12) @(posedge clk);
      #1;
      check("t3_accepted", 64'(acc_cnt - base), 64'd4);
      check("t3_in_ready", 64'(bif.in_ready), 64'd0);
      check("t3_head",     64'(bif.out_data), 64'd6);
      @(posedge clk); #1;
      check("t3_head_hold", 64'(bif.out_data), 64'd6);
      bif.out_ready = 1'b1;
      wait_drain(40);
      check("t3_accepted_all", 64'(acc_cnt - base), 64'd6);
      check("t3_received",     64'(rcv_cnt - rbase), 64'd6);

      // 4: streaming with random backpressure
      rbase = rcv_cnt;
      for (int i = 0; i < 64; i++) begin
         a = int'($urandom_range(0, int'(Prime) - 1));
         b = int'($urandom_range(0, int'(Prime) - 1));
         put(a, b, int'((64'(a) * 64'(b)) % 64'(Prime)), 1);
      end
      rand_rdy = 1;
      wait_drain(1500);
      rand_rdy = 0;
      @(posedge clk); #2;
      bif.out_ready = 1'b1;
      check("t4_received", 64'(rcv_cnt - rbase), 64'd64);
      check("fifo_overflow", 64'(ovf_cnt), 64'd0);

      // 5: range error is sticky
      check("t5_pre_err", 64'(range_err), 64'd0);
      base = acc_cnt;
      put(2146043, 1, 0, 0);
      wait_acc(base + 1);
      t = last_acc;
      wait_to(t);
      check("t5_err_set", 64'(range_err), 64'd1);
      put(6, 7, 42, 1);
      wait_drain(30);
      check("t5_err_sticky", 64'(range_err), 64'd1);

      // 6: reset with ops in flight and a result queued
      bif.out_ready = 1'b0;
      base = acc_cnt;
      put(2, 2, 4, 1); put(3, 3, 9, 1); put(4, 4, 16, 1); put(5, 5, 25, 1);
      wait_acc(base + 4);
      t = last_acc;
      wait_to(t);
      check("t6_pre_ov", 64'(bif.out_valid), 64'd1);
      #1;
      rst = 1'b1;
      stim.delete();
      exp_q.delete();
      bif.in_valid = 1'b0;
      #1;
      check("t6_rst_ov",  64'(bif.out_valid), 64'd0);
      check("t6_rst_ir",  64'(bif.in_ready),  64'd0);
      check("t6_rst_err", 64'(range_err),     64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      bif.out_ready = 1'b1;
      rbase = rcv_cnt;
      repeat (6) @(posedge clk);
      #1;
      check("t6_no_stale", 64'(bif.out_valid), 64'd0);
      put(7, 9, 63, 1);
      wait_drain(20);
      check("t6_received", 64'(rcv_cnt - rbase), 64'd1);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
